// File: rtl/camera_pkg.sv
// ----------------------------------------------------------------------------
// camera_pkg : key codes, controller state type and direction selector
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package camera_pkg;

  typedef logic [2:0] key_t;

  localparam key_t KEY_UPOS = 3'b000;
  localparam key_t KEY_UNEG = 3'b001;
  localparam key_t KEY_VPOS = 3'b010;
  localparam key_t KEY_VNEG = 3'b011;
  localparam key_t KEY_WPOS = 3'b100;
  localparam key_t KEY_WNEG = 3'b101;
  localparam key_t KEY_IDLE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_ISSUE = 2'd2
  } ctrl_state_e;

  // A pair with both buttons down cancels; the lowest surviving pair wins.
  function automatic key_t select_key(input logic [5:0] db);
    if (db[0] ^ db[1]) return db[1] ? KEY_UNEG : KEY_UPOS;
    if (db[2] ^ db[3]) return db[3] ? KEY_VNEG : KEY_VPOS;
    if (db[4] ^ db[5]) return db[5] ? KEY_WNEG : KEY_WPOS;
    return KEY_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/camera_btn_debounce.sv
// ----------------------------------------------------------------------------
// camera_btn_debounce : 2-FF synchroniser plus stable-run debouncer, one bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module camera_btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic db_o
);

  localparam int                  c_CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DEBOUNCE_CYC - 1);

  logic               sync1_q;
  logic               sync2_q;
  logic               db_q;
  logic [c_CNT_W-1:0] stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      stable_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        stable_q <= '0;
      end else if (stable_q == c_LAST) begin
        db_q     <= sync2_q;
        stable_q <= '0;
      end else begin
        stable_q <= stable_q + 1'b1;
      end
    end
  end

  assign db_o = db_q;

endmodule

`default_nettype wire

// File: rtl/camera_key_ctrl.sv
// ----------------------------------------------------------------------------
// camera_key_ctrl : buttons -> (key, cnt, ld_curr_camera) update stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module camera_key_ctrl
  import camera_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int MIN_GAP      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  btn,
  input  logic        frame_tick,
  output logic [2:0]  key,
  output logic [31:0] cnt,
  output logic        ld_curr_camera
);

  localparam int c_GAP_W = $clog2(MIN_GAP);

  logic [5:0]         db;
  key_t               sel;
  ctrl_state_e        state_q, state_d;
  key_t               cur_key_q, cur_key_d;
  key_t               key_q, key_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic [c_GAP_W-1:0] gap_q, gap_d;
  logic               held;
  logic               flush_req;
  logic               take;

  for (genvar i = 0; i < 6; i++) begin : g_btn
    camera_btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_i(btn[i]),
      .db_o (db[i])
    );
  end

  assign sel       = select_key(db);
  assign held      = (cur_key_q != KEY_IDLE);
  assign flush_req = (acc_q != '0) && (frame_tick || (sel != cur_key_q));
  assign take      = (state_q == ST_MOVE) && (flush_req || flush_pend_q) && (gap_q == '0);

  always_comb begin
    state_d      = state_q;
    cur_key_d    = cur_key_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q | flush_req;
    acc_d        = (held && (acc_q != '1)) ? acc_q + 32'd1 : acc_q;
    gap_d        = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    case (state_q)
      ST_IDLE: begin
        if (sel != KEY_IDLE) begin
          state_d   = ST_MOVE;
          cur_key_d = sel;
        end
      end
      ST_MOVE: begin
        if (take) begin
          state_d      = ST_ISSUE;
          key_d        = cur_key_q;
          cnt_d        = acc_q;
          cur_key_d    = sel;
          flush_pend_d = 1'b0;
          // The take cycle itself belongs to the next run only if a key is still down.
          acc_d        = (sel != KEY_IDLE) ? 32'd1 : 32'd0;
        end
      end
      ST_ISSUE: begin
        gap_d   = c_GAP_W'(MIN_GAP - 1);
        state_d = held ? ST_MOVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_key_q    <= KEY_IDLE;
      key_q        <= KEY_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_key_q    <= cur_key_d;
      key_q        <= key_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      gap_q        <= gap_d;
    end
  end

  assign key            = key_q;
  assign cnt            = cnt_q;
  assign ld_curr_camera = (state_q == ST_ISSUE);

endmodule

`default_nettype wire

// File: tb/tb_camera_key_ctrl.sv
// ----------------------------------------------------------------------------
// tb_camera_key_ctrl : randomized hold/tick scenarios against pulse-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_camera_key_ctrl;
  import camera_pkg::*;

  localparam int DEB = 4;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  btn = '0;
  logic        frame_tick = 1'b0;
  logic [2:0]  key;
  logic [31:0] cnt;
  logic        ld_curr_camera;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pulse = -100;

  key_t        pk[$];
  logic [31:0] pc[$];
  int          pt[$];

  camera_key_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .MIN_GAP     (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .frame_tick    (frame_tick),
    .key           (key),
    .cnt           (cnt),
    .ld_curr_camera(ld_curr_camera)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned sum_from(input int first);
    int unsigned s = 0;
    for (int i = first; i < pc.size(); i++) s += pc[i];
    return s;
  endfunction

  // Pulse recorder: every update must carry a non-zero count and respect the gap.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pulse = -100;
    end else if (ld_curr_camera) begin
      check("pulse_cnt_nonzero", 32'(cnt != 0), 32'd1);
      check("pulse_spacing", 32'((cyc - last_pulse) >= GAP), 32'd1);
      last_pulse = cyc;
      pk.push_back(key);
      pc.push_back(cnt);
      pt.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, h, nt, n, p, q;

    // Reset state and idle frame ticks
    repeat (3) step();
    check("rst_key", 32'(key), 32'(KEY_IDLE));
    check("rst_cnt", cnt, 32'd0);
    check("rst_ld", 32'(ld_curr_camera), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (3 + $urandom_range(0, 5)) step();
    end
    check("t1_pulses", pk.size(), 32'd0);
    check("t1_key", 32'(key), 32'(KEY_IDLE));
    check("t1_cnt", cnt, 32'd0);

    // Short glitch is filtered, then a single held press issues one update on release
    btn[0] = 1'b1;
    repeat (3) step();
    btn[0] = 1'b0;
    repeat (20) step();
    check("t2_glitch_pulses", pk.size(), 32'd0);
    h = 60 + int'($urandom_range(0, 60));
    btn[0] = 1'b1;
    repeat (h) step();
    btn[0] = 1'b0;
    repeat (30) step();
    check("t2_pulses", pk.size(), 32'd1);
    if (pk.size() == 1) begin
      check("t2_key", 32'(pk[0]), 32'(KEY_UPOS));
      // H debounced cycles, minus the first one spent leaving IDLE
      check("t2_cnt", pc[0], 32'(h - 1));
    end

    // Held direction with a frame tick every 20 cycles
    base = pk.size();
    h = 100 + int'($urandom_range(0, 50));
    nt = 0;
    btn[2] = 1'b1;
    for (int c = 1; c <= h; c++) begin
      step();
      if (c == h) btn[2] = 1'b0;
      frame_tick = (c < h) && (c >= 30) && (((c - 30) % 20) == 0);
      if (frame_tick) nt++;
    end
    step();
    frame_tick = 1'b0;
    repeat (30) step();
    check("t3_pulses", pk.size() - base, 32'(nt + 1));
    check("t3_total", sum_from(base), 32'(h - 1));
    if (pk.size() >= base + 3) begin
      // Press at 0: counting starts at cycle 7, first tick at 30
      check("t3_first_cnt", pc[base], 32'd23);
      check("t3_steady_cnt", pc[base + 1], 32'd20);
      for (int i = base; i < pk.size(); i++) check("t3_key", 32'(pk[i]), 32'(KEY_VPOS));
    end

    // Cancelled pair, then an unrelated button
    base = pk.size();
    btn[5:4] = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      step();
      frame_tick = (c == 20);
    end
    check("t4_cancel_pulses", pk.size() - base, 32'd0);
    check("t4_cancel_key", 32'(key), 32'(KEY_VPOS));
    h = 50 + int'($urandom_range(0, 40));
    btn[1] = 1'b1;
    for (int c = 1; c <= h; c++) begin
      step();
      if (c == h) btn[1] = 1'b0;
      frame_tick = (c == 25);
    end
    repeat (30) step();
    btn[5:4] = 2'b00;
    repeat (20) step();
    check("t4_pulses", pk.size() - base, 32'd2);
    check("t4_total", sum_from(base), 32'(h - 1));
    if (pk.size() == base + 2) begin
      check("t4_key0", 32'(pk[base]), 32'(KEY_UNEG));
      check("t4_key1", 32'(pk[base + 1]), 32'(KEY_UNEG));
      check("t4_cnt0", pc[base], 32'd18);
    end

    // Direction change lands one cycle after a tick-triggered update
    base = pk.size();
    n = 40 + int'($urandom_range(0, 20));
    p = n - 4;
    h = 30 + int'($urandom_range(0, 30));
    btn[3] = 1'b1;
    for (int c = 1; c <= p + h; c++) begin
      step();
      if (c == p) btn = 6'b000001;
      if (c == p + h) btn = 6'b000000;
      frame_tick = (c == n);
    end
    repeat (30) step();
    check("t5_pulses", pk.size() - base, 32'd3);
    if (pk.size() == base + 3) begin
      check("t5_key0", 32'(pk[base]), 32'(KEY_VNEG));
      check("t5_key1", 32'(pk[base + 1]), 32'(KEY_VNEG));
      check("t5_key2", 32'(pk[base + 2]), 32'(KEY_UPOS));
      check("t5_cnt0", pc[base], 32'(n - 7));
      check("t5_vneg_total", pc[base] + pc[base + 1], 32'(n - 2));
      check("t5_upos_cnt", pc[base + 2], 32'(h - 3));
      check("t5_deferral", 32'(pt[base + 1] - pt[base]), 32'd5);
    end

    // Reset in the middle of a hold
    base = pk.size();
    btn[1] = 1'b1;
    repeat (50) step();
    check("t6_prereset_pulses", pk.size() - base, 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_key", 32'(key), 32'(KEY_IDLE));
    check("t6_rst_cnt", cnt, 32'd0);
    check("t6_rst_ld", 32'(ld_curr_camera), 32'd0);
    step();
    rst_n = 1'b1;
    q = 40 + int'($urandom_range(0, 40));
    for (int c = 1; c <= q; c++) begin
      step();
      if (c == q) btn[1] = 1'b0;
    end
    repeat (30) step();
    check("t6_pulses", pk.size() - base, 32'd1);
    if (pk.size() == base + 1) begin
      check("t6_key", 32'(pk[base]), 32'(KEY_UNEG));
      check("t6_cnt", pc[base], 32'(q - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
